lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues one word-bus transaction per EX memory op, stalling the pipeline until done.
// Optional macro MISALIGN_TRAP_EN: reject misaligned accesses with a misalign pulse instead of force-aligning them.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;
    logic        mis_q;
    logic [31:0] load_data_q;

    logic        capture;
    logic        ack_ok;
    logic        timeout;
    logic        trap_in;
    logic [31:0] load_ext;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        trap_in = 1'b0;
        if (funct3[1:0] == 2'b01)
            trap_in = addr[0];
        else if (funct3[1])
            trap_in = (addr[1:0] != 2'b00);
    end
`else
    assign trap_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bus_req = 1'b0;
        capture = 1'b0;
        ack_ok  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    state_d = trap_in ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                // An ack in the final allowed cycle wins over the timeout.
                if (bus_ack) begin
                    ack_ok  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            if (state_q == S_REQ && !bus_ack)
                cnt_q <= cnt_q + 16'd1;
            else
                cnt_q <= '0;
            if (capture) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
                we_q    <= mem_write;
                mis_q   <= trap_in;
                err_q   <= 1'b0;
            end
            if (ack_ok && !we_q)
                load_data_q <= load_ext;
            if (timeout) begin
                err_q       <= 1'b1;
                load_data_q <= '0;
            end
        end
    end

    // Lane selection for loads uses the captured address and size.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = bus_rdata[7:0];
        lane_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_q[1:0])
            2'b00:   lane_b = bus_rdata[7:0];
            2'b01:   lane_b = bus_rdata[15:8];
            2'b10:   lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = f3_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                bus_be    = 4'b0001 << addr_q[1:0];
                bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                bus_be    = 4'b1111;
                bus_wdata = wdata_q;
            end
        endcase
    end

    assign bus_we     = we_q;
    assign bus_addr   = {addr_q[31:2], 2'b00};
    assign load_data  = load_data_q;
    assign load_valid = (state_q == S_DONE) && !we_q && !err_q && !mis_q;
    assign bus_err    = (state_q == S_DONE) && err_q;
    assign fsm_state  = state_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign   = (state_q == S_DONE) && mis_q;
`else
    assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table for single accesses plus hand sequences for timeout, reset and misalignment.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] load_data;
    logic        load_valid, bus_err, misalign;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
        .misalign(misalign), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        logic        exp_lv;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        check("stall_on_request", stall, 1'b1);
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Scoreboard: every load_valid must match the oldest expected load result.
    always @(negedge clk) begin
        if (load_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL lv_unexpected: got load_valid 1 data 0x%08h expected no pulse", load_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (load_data !== e) begin
                    n_errors++;
                    $display("FAIL sb_load_data: got 0x%08h expected 0x%08h", load_data, e);
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        issue(v.rd, v.wr, v.f3, v.a, v.wd);
        check({tag, "_bus_req"}, bus_req, 1'b1);
        check({tag, "_bus_we"}, bus_we, v.exp_we);
        check({tag, "_bus_addr"}, bus_addr, v.exp_addr);
        check({tag, "_bus_be"}, bus_be, v.exp_be);
        if (v.exp_we) check({tag, "_bus_wdata"}, bus_wdata, v.exp_wdata);
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
        if (v.exp_lv) exp_q.push_back(v.exp_ld);
        step();
        bus_ack = 1'b0;
        check({tag, "_state_done"}, fsm_state, 2'd2);
        check({tag, "_stall_done"}, stall, 1'b0);
        check({tag, "_load_valid"}, load_valid, v.exp_lv);
        check({tag, "_bus_err"}, bus_err, 1'b0);
        if (v.exp_lv) check({tag, "_load_data"}, load_data, v.exp_ld);
        step();
        check({tag, "_state_idle"}, fsm_state, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b1, 3'b010, 32'h8,   32'hDEADBEEF, 32'h0,        1'b1, 32'h8,   4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        32'h1234F600, 1'b0, 32'h100, 4'b0010, 32'h0,        32'h000000F6, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 3'b001, 32'h6,   32'h0,        32'h80017FFF, 1'b0, 32'h4,   4'b1100, 32'h0,        32'hFFFF8001, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 3'b101, 32'h14,  32'h0,        32'h12349ABC, 1'b0, 32'h14,  4'b0011, 32'h0,        32'h00009ABC, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 3'b000, 32'h33,  32'h000000A5, 32'h0,        1'b1, 32'h30,  4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[7] = '{1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0, 32'h20,  4'b1111, 32'h0,        32'hCAFEF00D, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 3'b000, 32'h2,   32'h0,        32'h007F0000, 1'b0, 32'h0,   4'b0100, 32'h0,        32'h0000007F, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 3'b011, 32'h44,  32'h0,        32'h89ABCDEF, 1'b0, 32'h44,  4'b1111, 32'h0,        32'h89ABCDEF, 1'b1};

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_state", fsm_state, 2'd0);
        step();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Timeout: four REQ cycles without ack, then bus_err with cleared load_data.
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        n = 0;
        while (bus_req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("to_req_cycles", n, 4);
        check("to_bus_err", bus_err, 1'b1);
        check("to_load_valid", load_valid, 1'b0);
        check("to_load_data", load_data, 32'h0);
        check("to_stall", stall, 1'b0);
        step();
        check("to_err_pulse", bus_err, 1'b0);

        // Ack in the last allowed cycle succeeds; mem_read held in DONE is ignored.
        issue(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("last_req_hold", bus_req, 1'b1);
            step();
        end
        check("last_req_cycle4", bus_req, 1'b1);
        bus_ack = 1'b1;
        bus_rdata = 32'h11223344;
        exp_q.push_back(32'h11223344);
        step();
        bus_ack = 1'b0;
        mem_read = 1'b1;
        funct3 = 3'b010;
        check("last_load_valid", load_valid, 1'b1);
        check("last_bus_err", bus_err, 1'b0);
        check("last_load_data", load_data, 32'h11223344);
        step();
        check("done_ignores_read", fsm_state, 2'd0);
        mem_read = 1'b0;
        step();

        // Reset in the middle of a REQ aborts silently.
        issue(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
        step();
        check("mid_rst_in_req", bus_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_bus_req", bus_req, 1'b0);
        check("mid_rst_state", fsm_state, 2'd0);
        check("mid_rst_load_valid", load_valid, 1'b0);
        check("mid_rst_bus_err", bus_err, 1'b0);
        check("mid_rst_load_data", load_data, 32'h0);
        step();
        check("mid_rst_lv_after", load_valid, 1'b0);
        check("mid_rst_err_after", bus_err, 1'b0);

        // Stray ack while idle is ignored.
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        step();
        bus_ack = 1'b0;
        check("idle_ack_state", fsm_state, 2'd0);
        check("idle_ack_bus_req", bus_req, 1'b0);
        check("idle_ack_lv", load_valid, 1'b0);
        step();

`ifdef MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
        check("mis_bus_req", bus_req, 1'b0);
        check("mis_pulse", misalign, 1'b1);
        check("mis_load_valid", load_valid, 1'b0);
        check("mis_stall", stall, 1'b0);
        step();
        check("mis_pulse_end", misalign, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h203, 32'h5A5A5A5A);
        check("mis_st_bus_req", bus_req, 1'b0);
        check("mis_st_pulse", misalign, 1'b1);
        step();
`else
        issue(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
        check("mis_bus_req", bus_req, 1'b1);
        check("mis_bus_addr", bus_addr, 32'h40);
        check("mis_bus_be", bus_be, 4'b1111);
        check("mis_pulse", misalign, 1'b0);
        bus_ack = 1'b1;
        bus_rdata = 32'h5555AAAA;
        exp_q.push_back(32'h5555AAAA);
        step();
        bus_ack = 1'b0;
        check("mis_load_valid", load_valid, 1'b1);
        check("mis_done_pulse", misalign, 1'b0);
        step();
        issue(1'b1, 1'b0, 3'b001, 32'h7, 32'h0);
        check("mis_h_bus_addr", bus_addr, 32'h4);
        check("mis_h_bus_be", bus_be, 4'b1100);
        bus_ack = 1'b1;
        bus_rdata = 32'h7FFE0000;
        exp_q.push_back(32'h00007FFE);
        step();
        bus_ack = 1'b0;
        check("mis_h_load_data", load_data, 32'h00007FFE);
        step();
`endif

        repeat (2) step();
        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
